vram_dp_be: RTL and testbench

//  Parametrised true dual-port video RAM: byte-lane writes, registered reads with

---
 rtl/vram_dp_be.sv | 169 ++++++++++++++++
 tb/tb_vram_dp_be.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_dp_be.sv
// vram_dp_be: true dual-port video RAM with byte-lane writes and registered reads.
//   Port A serves the CPU/DMA side, port B the PPU fetch side. Both ports share
//   one clock. Reads have a selectable latency of 1 or 2 edges. An optional
//   post-reset sweep zeroes the whole array before any request is accepted.
// Ports:
//   clock                 rising-edge clock for all logic
//   reset_n               synchronous active-low reset (array contents untouched)
//   wren_x / rden_x       write / read request on port x (x = a, b)
//   byteena_x             lane enables, lane i = data_x[8i+7:8i]
//   address_x, data_x     word address and write data
//   q_x, valid_x          read data (held between results) and 1-cycle result pulse
//   busy                  high while the clear sweep runs; all requests ignored
module vram_dp_be #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 14,
    parameter int unsigned READ_LATENCY   = 1,
    parameter bit          RDW_NEW_DATA   = 1'b0,
    parameter bit          COLLIDE_B_WINS = 1'b0,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    wren_a,
    input  logic                    rden_a,
    input  logic [DATA_WIDTH/8-1:0] byteena_a,
    input  logic [ADDR_WIDTH-1:0]   address_a,
    input  logic [DATA_WIDTH-1:0]   data_a,
    output logic [DATA_WIDTH-1:0]   q_a,
    output logic                    valid_a,
    input  logic                    wren_b,
    input  logic                    rden_b,
    input  logic [DATA_WIDTH/8-1:0] byteena_b,
    input  logic [ADDR_WIDTH-1:0]   address_b,
    input  logic [DATA_WIDTH-1:0]   data_b,
    output logic [DATA_WIDTH-1:0]   q_b,
    output logic                    valid_b,
    output logic                    busy
);

    localparam int unsigned NumLanes = DATA_WIDTH / 8;
    localparam int unsigned Depth    = 2 ** ADDR_WIDTH;
    // Port written last in the edge wins shared lanes on a same-address collision.
    localparam int unsigned LoPri    = COLLIDE_B_WINS ? 32'd0 : 32'd1;
    localparam int unsigned HiPri    = 32'd1 - LoPri;

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("vram_dp_be: READ_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH % 8 != 0) begin : g_bad_width
        $error("vram_dp_be: DATA_WIDTH must be a multiple of 8");
    end

    typedef enum logic {StClear, StReady} state_e;

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q;
    logic                    busy_q;

    logic [DATA_WIDTH-1:0]   mem [Depth];

    // Port-indexed views: index 0 = A, 1 = B.
    logic [1:0]                   we;
    logic [1:0]                   re;
    logic [1:0][NumLanes-1:0]     be;
    logic [1:0][ADDR_WIDTH-1:0]   addr;
    logic [1:0][DATA_WIDTH-1:0]   wdata;
    logic [1:0][DATA_WIDTH-1:0]   rd_word;
    logic [1:0][DATA_WIDTH-1:0]   q_q;
    logic [1:0]                   valid_q;

    assign we    = {wren_b, wren_a} & {2{state_q == StReady}};
    assign re    = {rden_b, rden_a} & {2{state_q == StReady}};
    assign be    = {byteena_b, byteena_a};
    assign addr  = {address_b, address_a};
    assign wdata = {data_b, data_a};

    // Clear-sweep FSM; busy is a registered copy of "in StClear".
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= CLEAR_ON_RESET ? StClear : StReady;
            clr_cnt_q <= '0;
            busy_q    <= CLEAR_ON_RESET;
        end else if (state_q == StClear) begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
            if (clr_cnt_q == '1) begin
                state_q <= StReady;
                busy_q  <= 1'b0;
            end
        end
    end

    assign busy = busy_q;

    // Array writes. Reset itself never touches the contents.
    always_ff @(posedge clock) begin
        if (reset_n) begin
            if (state_q == StClear) begin
                mem[clr_cnt_q] <= '0;
            end else begin
                for (int i = 0; i < NumLanes; i++) begin
                    if (we[LoPri] && be[LoPri][i]) begin
                        mem[addr[LoPri]][8*i +: 8] <= wdata[LoPri][8*i +: 8];
                    end
                    if (we[HiPri] && be[HiPri][i]) begin
                        mem[addr[HiPri]][8*i +: 8] <= wdata[HiPri][8*i +: 8];
                    end
                end
            end
        end
    end

    // Read word as seen by each port this edge: array is pre-write, so cross-port
    // reads always return the old word; same-port merge only when RDW_NEW_DATA.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_word[p] = mem[addr[p]];
            if (RDW_NEW_DATA && we[p]) begin
                for (int i = 0; i < NumLanes; i++) begin
                    if (be[p][i]) begin
                        rd_word[p][8*i +: 8] = wdata[p][8*i +: 8];
                    end
                end
            end
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        if (READ_LATENCY == 1) begin : g_lat1
            always_ff @(posedge clock) begin
                if (!reset_n) begin
                    q_q[p]     <= '0;
                    valid_q[p] <= 1'b0;
                end else begin
                    valid_q[p] <= re[p];
                    if (re[p]) begin
                        q_q[p] <= rd_word[p];
                    end
                end
            end
        end else begin : g_lat2
            logic [DATA_WIDTH-1:0] s1_q;
            logic                  s1_valid_q;

            always_ff @(posedge clock) begin
                if (!reset_n) begin
                    s1_q       <= '0;
                    s1_valid_q <= 1'b0;
                    q_q[p]     <= '0;
                    valid_q[p] <= 1'b0;
                end else begin
                    s1_valid_q <= re[p];
                    if (re[p]) begin
                        s1_q <= rd_word[p];
                    end
                    valid_q[p] <= s1_valid_q;
                    if (s1_valid_q) begin
                        q_q[p] <= s1_q;
                    end
                end
            end
        end
    end

    assign q_a     = q_q[0];
    assign q_b     = q_q[1];
    assign valid_a = valid_q[0];
    assign valid_b = valid_q[1];

endmodule

// File: tb/tb_vram_dp_be.sv
// Bench for vram_dp_be: two instances sharing stimulus.
//   d0: defaults (14-bit address, latency 1, old-data RDW, A wins collisions)
//   d1: 6-bit address, latency 2, new-data RDW, B wins collisions
// A behavioural model (word arrays, per-port expected-result slots keyed by due
// cycle) checks every output after every edge; directed cases add literal checks.
module tb_vram_dp_be;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        wren_a = 1'b0, rden_a = 1'b0, wren_b = 1'b0, rden_b = 1'b0;
    logic [3:0]  be_a = '0, be_b = '0;
    logic [13:0] addr_a = '0, addr_b = '0;
    logic [31:0] data_a = '0, data_b = '0;

    logic [31:0] q_o [2][2];
    logic        v_o [2][2];
    logic        busy_o [2];

    always #5 clock = ~clock;

    vram_dp_be #(
        .DATA_WIDTH(32), .ADDR_WIDTH(14), .READ_LATENCY(1),
        .RDW_NEW_DATA(1'b0), .COLLIDE_B_WINS(1'b0), .CLEAR_ON_RESET(1'b1)
    ) u_dut0 (
        .clock(clock), .reset_n(reset_n),
        .wren_a(wren_a), .rden_a(rden_a), .byteena_a(be_a), .address_a(addr_a),
        .data_a(data_a), .q_a(q_o[0][0]), .valid_a(v_o[0][0]),
        .wren_b(wren_b), .rden_b(rden_b), .byteena_b(be_b), .address_b(addr_b),
        .data_b(data_b), .q_b(q_o[0][1]), .valid_b(v_o[0][1]),
        .busy(busy_o[0])
    );

    vram_dp_be #(
        .DATA_WIDTH(32), .ADDR_WIDTH(6), .READ_LATENCY(2),
        .RDW_NEW_DATA(1'b1), .COLLIDE_B_WINS(1'b1), .CLEAR_ON_RESET(1'b1)
    ) u_dut1 (
        .clock(clock), .reset_n(reset_n),
        .wren_a(wren_a), .rden_a(rden_a), .byteena_a(be_a), .address_a(addr_a[5:0]),
        .data_a(data_a), .q_a(q_o[1][0]), .valid_a(v_o[1][0]),
        .wren_b(wren_b), .rden_b(rden_b), .byteena_b(be_b), .address_b(addr_b[5:0]),
        .data_b(data_b), .q_b(q_o[1][1]), .valid_b(v_o[1][1]),
        .busy(busy_o[1])
    );

    // Reference configuration per instance.
    int unsigned dep [2]    = '{16384, 64};
    int unsigned lat [2]    = '{1, 2};
    bit          rdw_new[2] = '{1'b0, 1'b1};
    bit          b_wins [2] = '{1'b0, 1'b1};

    logic [31:0] m [2][16384];
    int unsigned busy_left [2] = '{0, 0};
    logic        exp_v [2][2][4];
    logic [31:0] exp_d [2][2][4];
    logic [31:0] last_q [2][2];

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    int unsigned cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] w = old;
        for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = nw[8*i +: 8];
        return w;
    endfunction

    task automatic post(input int d, input int p, input logic [31:0] v);
        int unsigned s = (cyc + lat[d]) % 4;
        exp_v[d][p][s] = 1'b1;
        exp_d[d][p][s] = v;
    endtask

    // Apply the coming edge's effect to the model of instance d.
    task automatic model_edge(input int d);
        int unsigned aa = addr_a % dep[d];
        int unsigned ab = addr_b % dep[d];
        logic [31:0] old_a, old_b, w;
        if (!reset_n) begin
            busy_left[d] = dep[d];
            for (int p = 0; p < 2; p++) begin
                last_q[d][p] = '0;
                for (int s = 0; s < 4; s++) exp_v[d][p][s] = 1'b0;
            end
            return;
        end
        if (busy_left[d] != 0) begin
            m[d][dep[d] - busy_left[d]] = '0;
            busy_left[d]--;
            return;
        end
        old_a = m[d][aa];
        old_b = m[d][ab];
        if (rden_a) post(d, 0, (rdw_new[d] && wren_a) ? merge(old_a, data_a, be_a) : old_a);
        if (rden_b) post(d, 1, (rdw_new[d] && wren_b) ? merge(old_b, data_b, be_b) : old_b);
        if (wren_a && wren_b && aa == ab) begin
            w = old_a;
            for (int i = 0; i < 4; i++) begin
                if (be_a[i] && be_b[i]) w[8*i +: 8] = b_wins[d] ? data_b[8*i +: 8]
                                                                 : data_a[8*i +: 8];
                else if (be_a[i]) w[8*i +: 8] = data_a[8*i +: 8];
                else if (be_b[i]) w[8*i +: 8] = data_b[8*i +: 8];
            end
            m[d][aa] = w;
        end else begin
            if (wren_a) m[d][aa] = merge(m[d][aa], data_a, be_a);
            if (wren_b) m[d][ab] = merge(m[d][ab], data_b, be_b);
        end
    endtask

    task automatic step();
        for (int d = 0; d < 2; d++) model_edge(d);
        @(posedge clock);
        #1;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                int unsigned s = cyc % 4;
                logic ev = exp_v[d][p][s];
                if (ev) last_q[d][p] = exp_d[d][p][s];
                exp_v[d][p][s] = 1'b0;
                check($sformatf("d%0d p%0d valid", d, p), v_o[d][p], ev);
                check($sformatf("d%0d p%0d q", d, p), q_o[d][p], last_q[d][p]);
            end
            check($sformatf("d%0d busy", d), busy_o[d], busy_left[d] != 0);
        end
    endtask

    task automatic idle();
        wren_a = 1'b0; rden_a = 1'b0; wren_b = 1'b0; rden_b = 1'b0;
    endtask

    task automatic count_busy(input string tag);
        int unsigned cnt = 0;
        while (busy_o[0] === 1'b1 && cnt < 20000) begin
            step();
            cnt++;
        end
        check(tag, cnt, 32'd16384);
    endtask

    initial begin
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) begin
                last_q[d][p] = '0;
                for (int s = 0; s < 4; s++) exp_v[d][p][s] = 1'b0;
            end
        for (int i = 0; i < 16384; i++) begin
            m[0][i] = '0;
            m[1][i] = '0;
        end

        // Reset and full clear sweep.
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        count_busy("t1 busy cycles");
        rden_a = 1'b1; addr_a = 14'h3FFF;
        step();
        check("t1 q 0x3fff", q_o[0][0], 32'h0);
        check("t1 valid", v_o[0][0], 1'b1);
        idle();
        step();

        // Byte-lane overwrite.
        wren_a = 1'b1; addr_a = 14'h10; be_a = 4'hF; data_a = 32'hDEADBEEF;
        step();
        be_a = 4'h2; data_a = 32'h0000AA00;
        step();
        idle(); rden_a = 1'b1;
        step();
        check("t2 q", q_o[0][0], 32'hDEADAAEF);
        check("t2 valid", v_o[0][0], 1'b1);
        idle();
        step();
        check("t2 valid drop", v_o[0][0], 1'b0);

        // Same-address dual write.
        wren_a = 1'b1; addr_a = 14'h20; be_a = 4'h3; data_a = 32'h11111111;
        wren_b = 1'b1; addr_b = 14'h20; be_b = 4'h6; data_b = 32'h22222222;
        step();
        idle(); rden_a = 1'b1;
        step();
        check("t3 a-wins", q_o[0][0], 32'h00221111);
        idle();
        step();
        check("t3 b-wins", q_o[1][0], 32'h00222211);

        // Read-during-write on A, cross-port read on B.
        wren_a = 1'b1; addr_a = 14'h30; be_a = 4'hF; data_a = 32'h12345678;
        step();
        be_a = 4'h8; data_a = 32'hAB000000; rden_a = 1'b1;
        rden_b = 1'b1; addr_b = 14'h30;
        step();
        check("t4 rdw old", q_o[0][0], 32'h12345678);
        check("t4 cross d0", q_o[0][1], 32'h12345678);
        idle();
        step();
        check("t4 rdw new", q_o[1][0], 32'hAB345678);
        check("t4 cross d1", q_o[1][1], 32'h12345678);

        // Latency-2 back-to-back reads.
        for (int i = 1; i <= 3; i++) begin
            wren_a = 1'b1; addr_a = 14'(i); be_a = 4'hF; data_a = 32'h11110000 + 32'(i);
            step();
        end
        idle();
        for (int i = 1; i <= 5; i++) begin
            rden_b = (i <= 3); addr_b = 14'(i);
            step();
            if (i == 1) check("t5 no early valid", v_o[1][1], 1'b0);
            else if (i <= 4) begin
                check("t5 valid", v_o[1][1], 1'b1);
                check("t5 order", q_o[1][1], 32'h11110000 + 32'(i - 1));
            end else check("t5 valid end", v_o[1][1], 1'b0);
        end

        // Randomised traffic with frequent collisions.
        for (int n = 0; n < 3000; n++) begin
            wren_a = 1'($urandom_range(0, 1)); rden_a = 1'($urandom_range(0, 1));
            wren_b = 1'($urandom_range(0, 1)); rden_b = 1'($urandom_range(0, 1));
            be_a = 4'($urandom); be_b = 4'($urandom);
            addr_a = 14'($urandom_range(0, 15)); addr_b = 14'($urandom_range(0, 15));
            data_a = $urandom; data_b = $urandom;
            step();
        end
        idle();
        step();
        step();

        // Reset mid-sweep with reads in flight on d1.
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            rden_b = (i >= 99); addr_b = 14'h2;
            step();
        end
        idle();
        reset_n = 1'b0;
        step();
        check("t6 no valid", v_o[1][1], 1'b0);
        check("t6 busy", busy_o[0], 1'b1);
        reset_n = 1'b1;
        count_busy("t6 busy cycles");
        rden_a = 1'b1; addr_a = 14'h10;
        step();
        check("t6 cleared", q_o[0][0], 32'h0);
        idle();
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
